roberto_rx_quadro: RTL and testbench
====================================

// Module: roberto_rx_quadro
// PURPOSE
//  Downstream consumer of the serial output of the roberto top level: receives the ASCII
//  measurement frame "DDD,DDD,DDD#" (sensors 1,2,3, centimetres, 3 BCD digits each) and
//  rebuilds the three distances as parallel BCD words with a frame-valid pulse.
//  Sits on the receiving board (or in a loopback test top) between the serial pin and the display/host logic.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per serial bit (50 MHz / 115200 baud)
// PORTS
//  clock          in   1   system clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  entrada_serial in   1   serial line, idle high; 7 data bits LSB first, odd parity, 1 stop
//  medida1        out  12  sensor 1 distance, BCD {hundreds,tens,units}
//  medida2        out  12  sensor 2 distance, BCD
//  medida3        out  12  sensor 3 distance, BCD
//  pronto         out  1   1-cycle pulse: complete valid frame latched into medida1..3
//  erro           out  1   1-cycle pulse: parity, stop-bit or format error detected
//  db_estado      out  4   debug: current receiver FSM state code
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, FSMs to IDLE/index 0, resync flag clear.
//  Input: entrada_serial through a 2-flop synchronizer (reset value 1) before any use.
//  Bit FSM: IDLE(0) -> START(1) on synchronized falling edge; START waits CLKS_PER_BIT/2 and
//   re-samples: still 0 -> DATA(2), else back to IDLE (glitch, no erro).
//   DATA samples 7 bits, one every CLKS_PER_BIT, at bit centre -> PARIDADE(3) -> STOP(4).
//   STOP sample: 1 with odd parity OK -> CHAR(5) for one cycle; else erro pulse, IDLE.
//   CHAR -> IDLE next cycle. Baud counter is 0 on every state entry.
//  Frame parser (advances only in CHAR), index i = 0..11:
//   i in {0,1,2,4,5,6,8,9,10}: char must be '0'..'9' (0x30-0x39); low nibble shifted into
//    shadow register of the current measurement, i+1.
//   i in {3,7}: char must be ',' (0x2C); i+1.
//   i = 11: char must be '#' (0x23); copy shadows to medida1..3 and pulse pronto in the
//    cycle after CHAR; i <- 0.
//   Mismatch at any i: erro pulse, shadows unchanged at outputs; if char is '#' i <- 0
//    immediately, else set resync flag and discard chars until a '#', then i <- 0.
//  medida1..3 change only on pronto; hold otherwise (partial/bad frames never visible).
//  Latency: pronto rises exactly 2 clocks after the stop-bit centre sample of '#'.
//  pronto and erro never asserted in the same cycle; erro from a bad stop/parity also
//   forces resync (frame position unknown).
//  Line held low (break): one START/DATA pass, stop=0 -> erro, then IDLE waits for high before
//   a new falling edge is accepted (no repeated erro while low).
//  Reset mid-character or mid-frame: character and frame discarded, outputs return to 0.
//  db_estado: {0:IDLE,1:START,2:DATA,3:PARIDADE,4:STOP,5:CHAR}; bit widths in this block are fixed (7-bit char).
// TESTING
//  1 Send "123,045,300#" at CLKS_PER_BIT=434 -> one pronto; medida1=12'h123, medida2=12'h045,
//    medida3=12'h300; erro never high.
//  2 Two back-to-back frames "001,002,003#" "999,000,500#" -> two pronto pulses; outputs
//    after second = 999/000/500; between frames outputs hold 001/002/003.
//  3 Char '2' with parity bit flipped inside frame -> erro pulse; no pronto; following
//    "111,222,333#" -> erro-free pronto with 111/222/333 (resync after '#' of bad frame).
//  4 "12#" -> erro at '#', i reset; immediately "456,789,012#" -> pronto, 456/789/012.
//  5 250 ns low glitch on idle line -> START aborts to IDLE, no erro, no pronto.
//  6 Drive reset=0 mid-data-bit of 6th character -> all outputs 0 asynchronously; after
//    release a full frame "010,020,030#" -> pronto with 010/020/030.

Source files
------------

// File: rtl/roberto_rx_quadro.sv
// Serial receiver for the "DDD,DDD,DDD#" measurement frame: 7O1 character
// receiver plus frame parser that publishes three BCD distances atomically.
module roberto_rx_quadro #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] medida1,
  output logic [11:0] medida2,
  output logic [11:0] medida3,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    START    = 4'd1,
    DATA     = 4'd2,
    PARIDADE = 4'd3,
    STOP     = 4'd4,
    CHAR     = 4'd5
  } state_t;

  localparam int            CW     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [6:0]    HASH   = 7'h23;
  localparam logic [6:0]    COMMA  = 7'h2C;

  state_t          state_q;
  logic [1:0]      sync_q;
  logic            rx_prev_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bitn_q;
  logic [6:0]      shift_q;
  logic            par_q;
  logic [3:0]      idx_q;
  logic            resync_q;
  logic [2:0][11:0] sh_q;
  logic [11:0]     medida1_q, medida2_q, medida3_q;
  logic            pronto_q, erro_q;

  logic rx;
  logic is_digit;
  logic is_sep_pos;

  assign rx         = sync_q[1];
  assign is_digit   = (shift_q[6:4] == 3'h3) && (shift_q[3:0] < 4'd10);
  assign is_sep_pos = (idx_q == 4'd3) || (idx_q == 4'd7);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bitn_q    <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      idx_q     <= '0;
      resync_q  <= 1'b0;
      sh_q      <= '0;
      medida1_q <= '0;
      medida2_q <= '0;
      medida3_q <= '0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], entrada_serial};
      rx_prev_q <= rx;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // Edge-triggered start: a line stuck low never re-arms the receiver.
          if (rx_prev_q && !rx) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF) begin
            cnt_q  <= '0;
            bitn_q <= '0;
            state_q <= rx ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            shift_q <= {rx, shift_q[6:1]};
            bitn_q  <= bitn_q + 3'd1;
            if (bitn_q == 3'd6) state_q <= PARIDADE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PARIDADE: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            par_q   <= rx;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == FULL) begin
            cnt_q <= '0;
            if (rx && (^{shift_q, par_q})) begin
              state_q <= CHAR;
            end else begin
              // Lost character: frame position is unknown, hunt for the next '#'.
              erro_q   <= 1'b1;
              resync_q <= 1'b1;
              state_q  <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        CHAR: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          if (resync_q) begin
            if (shift_q == HASH) begin
              resync_q <= 1'b0;
              idx_q    <= '0;
            end
          end else if (idx_q == 4'd11) begin
            idx_q <= '0;
            if (shift_q == HASH) begin
              medida1_q <= sh_q[0];
              medida2_q <= sh_q[1];
              medida3_q <= sh_q[2];
              pronto_q  <= 1'b1;
            end else begin
              erro_q   <= 1'b1;
              resync_q <= 1'b1;
            end
          end else if (is_sep_pos ? (shift_q == COMMA) : is_digit) begin
            if (!is_sep_pos) sh_q[idx_q[3:2]] <= {sh_q[idx_q[3:2]][7:0], shift_q[3:0]};
            idx_q <= idx_q + 4'd1;
          end else begin
            // A stray '#' already marks a frame boundary; anything else needs a hunt.
            erro_q   <= 1'b1;
            idx_q    <= '0;
            resync_q <= (shift_q != HASH);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign medida1   = medida1_q;
  assign medida2   = medida2_q;
  assign medida3   = medida3_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;
  assign db_estado = state_q;

endmodule

// File: tb/tb_roberto_rx_quadro.sv
// Directed bench for roberto_rx_quadro: frames driven bit by bit, expected
// measurement triples queued on send and checked when pronto pulses.
module tb_roberto_rx_quadro;
  localparam int CPB = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        entrada_serial = 1'b1;
  logic [11:0] medida1, medida2, medida3;
  logic        pronto, erro;
  logic [3:0]  db_estado;

  int checks = 0;
  int errors = 0;
  int pronto_cnt = 0;
  int erro_cnt = 0;
  bit saw_start = 1'b0;
  logic [35:0] exp_q[$];

  roberto_rx_quadro #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .entrada_serial(entrada_serial),
    .medida1(medida1), .medida2(medida2), .medida3(medida3),
    .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (db_estado == 4'd1) saw_start = 1'b1;
    if (pronto || erro) check("pronto_erro_exclusive", {35'd0, pronto & erro}, 36'd0);
    if (erro) erro_cnt++;
    if (pronto) begin
      pronto_cnt++;
      check("sb_nonempty", {35'd0, exp_q.size() != 0}, 36'd1);
      if (exp_q.size() != 0) check("sb_frame", {medida1, medida2, medida3}, exp_q.pop_front());
    end
  end

  task automatic send_bit(input logic b, input int cycles);
    entrada_serial = b;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic send_char(input logic [7:0] c, input bit flip);
    send_bit(1'b0, CPB);
    for (int i = 0; i < 7; i++) send_bit(c[i], CPB);
    send_bit((~^c[6:0]) ^ flip, CPB);
    send_bit(1'b1, CPB);
  endtask

  task automatic send_str(input string s, input int flip_idx);
    for (int i = 0; i < s.len(); i++) send_char(s[i], i == flip_idx);
  endtask

  task automatic settle();
    entrada_serial = 1'b1;
    repeat (2 * CPB) @(negedge clock);
  endtask

  task automatic check_out(input string tag, input logic [35:0] exp);
    check(tag, {medida1, medida2, medida3}, exp);
  endtask

  initial begin
    int p0, e0;
    repeat (5) @(negedge clock);
    check("rst_out", {medida1, medida2, medida3}, 36'h0);
    check("rst_flags", {30'd0, pronto, erro, db_estado}, 36'h0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_state", {32'd0, db_estado}, 36'd0);

    // Basic frame
    p0 = pronto_cnt; e0 = erro_cnt;
    exp_q.push_back(36'h123_045_300);
    send_str("123,045,300#", -1);
    settle();
    check("t1_pronto_cnt", pronto_cnt - p0, 1);
    check("t1_erro_cnt", erro_cnt - e0, 0);
    check_out("t1_out", 36'h123_045_300);

    // Back-to-back frames, outputs hold between them
    p0 = pronto_cnt; e0 = erro_cnt;
    exp_q.push_back(36'h001_002_003);
    send_str("001,002,003#", -1);
    check_out("t2_hold", 36'h001_002_003);
    send_str("999,000", -1);
    check_out("t2_hold_partial", 36'h001_002_003);
    exp_q.push_back(36'h999_000_500);
    send_str(",500#", -1);
    settle();
    check("t2_pronto_cnt", pronto_cnt - p0, 2);
    check("t2_erro_cnt", erro_cnt - e0, 0);
    check_out("t2_out", 36'h999_000_500);

    // Parity error inside a frame, then resync on its '#'
    p0 = pronto_cnt; e0 = erro_cnt;
    send_str("123,456,789#", 1);
    settle();
    check("t3_bad_erro", erro_cnt - e0, 1);
    check("t3_bad_pronto", pronto_cnt - p0, 0);
    check_out("t3_hold", 36'h999_000_500);
    e0 = erro_cnt;
    exp_q.push_back(36'h111_222_333);
    send_str("111,222,333#", -1);
    settle();
    check("t3_good_pronto", pronto_cnt - p0, 1);
    check("t3_good_erro", erro_cnt - e0, 0);
    check_out("t3_out", 36'h111_222_333);

    // Early '#': error, index back to 0 with no hunt
    p0 = pronto_cnt; e0 = erro_cnt;
    send_str("12#", -1);
    check("t4_short_erro", erro_cnt - e0, 1);
    exp_q.push_back(36'h456_789_012);
    send_str("456,789,012#", -1);
    settle();
    check("t4_erro_total", erro_cnt - e0, 1);
    check("t4_pronto", pronto_cnt - p0, 1);
    check_out("t4_out", 36'h456_789_012);

    // Short glitch aborts in START
    p0 = pronto_cnt; e0 = erro_cnt; saw_start = 1'b0;
    entrada_serial = 1'b0;
    #250;
    entrada_serial = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    check("t5_saw_start", {35'd0, saw_start}, 36'd1);
    check("t5_state", {32'd0, db_estado}, 36'd0);
    check("t5_erro", erro_cnt - e0, 0);
    check("t5_pronto", pronto_cnt - p0, 0);

    // Break: one erro only while the line stays low
    p0 = pronto_cnt; e0 = erro_cnt;
    entrada_serial = 1'b0;
    repeat (20 * CPB) @(negedge clock);
    check("brk_erro", erro_cnt - e0, 1);
    check("brk_state", {32'd0, db_estado}, 36'd0);
    settle();
    check("brk_pronto", pronto_cnt - p0, 0);
    check_out("brk_hold", 36'h456_789_012);

    // Asynchronous reset in a data bit of the 6th character
    send_str("010,0", -1);
    send_bit(1'b0, CPB);
    send_bit(1'b0, CPB / 2);
    #3 reset = 1'b0;
    #1;
    check("t6_async_out", {medida1, medida2, medida3}, 36'h0);
    check("t6_async_state", {32'd0, db_estado}, 36'd0);
    entrada_serial = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    p0 = pronto_cnt; e0 = erro_cnt;
    exp_q.push_back(36'h010_020_030);
    send_str("010,020,030#", -1);
    settle();
    check("t6_pronto", pronto_cnt - p0, 1);
    check("t6_erro", erro_cnt - e0, 0);
    check_out("t6_out", 36'h010_020_030);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
